alu_result_stage: RTL and testbench

//   Pipeline stage directly downstream of the Alu. Registers each Alu result

---
 rtl/alu_result_stage_if.sv | 53 +++++
 rtl/alu_result_stage.sv | 87 ++++++++
 tb/tb_alu_result_stage.sv | 305 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_result_stage_if.sv
// Handshake bundle between the Alu, the result stage and writeback.
// The stage uses the slave view; the Alu/writeback side uses master.
interface alu_result_stage_if #(
   parameter int WORD_WIDTH    = 32,
   parameter int REG_IDX_WIDTH = 4,
   parameter int FLAGS_WIDTH   = 4
);
   logic                     in_valid;
   logic                     in_ready;
   logic [WORD_WIDTH-1:0]    in_result;
   logic [FLAGS_WIDTH-1:0]   in_flags;
   logic                     in_update_flags;
   logic                     in_write_reg;
   logic [REG_IDX_WIDTH-1:0] in_dest_reg;
   logic [FLAGS_WIDTH-1:0]   cur_flags;
   logic                     out_valid;
   logic                     out_ready;
   logic [WORD_WIDTH-1:0]    out_result;
   logic                     out_write_reg;
   logic [REG_IDX_WIDTH-1:0] out_dest_reg;

   modport slave (
      input  in_valid,
      input  in_result,
      input  in_flags,
      input  in_update_flags,
      input  in_write_reg,
      input  in_dest_reg,
      input  out_ready,
      output in_ready,
      output cur_flags,
      output out_valid,
      output out_result,
      output out_write_reg,
      output out_dest_reg
   );

   modport master (
      output in_valid,
      output in_result,
      output in_flags,
      output in_update_flags,
      output in_write_reg,
      output in_dest_reg,
      output out_ready,
      input  in_ready,
      input  cur_flags,
      input  out_valid,
      input  out_result,
      input  out_write_reg,
      input  out_dest_reg
   );
endinterface

// File: rtl/alu_result_stage.sv
// Alu result stage: 2-entry main/skid buffer with valid/ready on both
// sides, plus the architectural N,V,Z,C flags register fed back to the Alu.
module alu_result_stage #(
   parameter int WORD_WIDTH    = 32,
   parameter int REG_IDX_WIDTH = 4,
   parameter int FLAGS_WIDTH   = 4
) (
   input logic clk,
   input logic rst,
   input logic flush,
   alu_result_stage_if.slave bus
);
   localparam int BEAT_W = WORD_WIDTH + REG_IDX_WIDTH + 1;

   logic              main_valid_q, main_valid_d;
   logic              skid_valid_q, skid_valid_d;
   logic [BEAT_W-1:0] main_beat_q, main_beat_d;
   logic [BEAT_W-1:0] skid_beat_q, skid_beat_d;
   logic [FLAGS_WIDTH-1:0] flags_q, flags_d;
   logic [BEAT_W-1:0] in_beat;
   logic              in_ready;
   logic              out_valid;
   logic              accept;
   logic              drain;

   assign in_beat = {bus.in_write_reg, bus.in_dest_reg, bus.in_result};

   // in_ready depends only on registered skid state, never on out_ready
   assign in_ready  = !skid_valid_q && !rst && !flush;
   assign out_valid = main_valid_q && !rst;
   assign accept    = bus.in_valid && in_ready;
   assign drain     = out_valid && bus.out_ready;

   assign bus.in_ready  = in_ready;
   assign bus.out_valid = out_valid;
   assign bus.cur_flags = rst ? '0 : flags_q;
   assign {bus.out_write_reg, bus.out_dest_reg, bus.out_result} =
      out_valid ? main_beat_q : '0;

   always_comb begin
      main_valid_d = main_valid_q;
      skid_valid_d = skid_valid_q;
      main_beat_d  = main_beat_q;
      skid_beat_d  = skid_beat_q;
      flags_d      = flags_q;
      if (accept && bus.in_update_flags) begin
         flags_d = bus.in_flags;
      end
      if (flush) begin
         main_valid_d = 1'b0;
         skid_valid_d = 1'b0;
      end else if (!main_valid_q) begin
         if (accept) begin
            main_valid_d = 1'b1;
            main_beat_d  = in_beat;
         end
      end else if (!skid_valid_q) begin
         if (drain && accept) begin
            main_beat_d = in_beat;
         end else if (drain) begin
            main_valid_d = 1'b0;
         end else if (accept) begin
            skid_valid_d = 1'b1;
            skid_beat_d  = in_beat;
         end
      end else if (drain) begin
         main_beat_d  = skid_beat_q;
         skid_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         main_valid_q <= 1'b0;
         skid_valid_q <= 1'b0;
         main_beat_q  <= '0;
         skid_beat_q  <= '0;
         flags_q      <= '0;
      end else begin
         main_valid_q <= main_valid_d;
         skid_valid_q <= skid_valid_d;
         main_beat_q  <= main_beat_d;
         skid_beat_q  <= skid_beat_d;
         flags_q      <= flags_d;
      end
   end
endmodule

// File: tb/tb_alu_result_stage.sv
// Scoreboard bench for alu_result_stage: accepted beats are queued and
// checked in order as writeback drains them.
module tb_alu_result_stage;
   localparam int FLAG_N = 3;
   localparam int FLAG_V = 2;
   localparam int FLAG_Z = 1;
   localparam int FLAG_C = 0;

   logic clk;
   logic rst;
   logic flush;
   int   tests;
   int   fails;
   int   delivered;
   logic [3:0]  exp_flags;
   logic [36:0] sb_q[$];

   alu_result_stage_if #(.WORD_WIDTH(32), .REG_IDX_WIDTH(4),
                         .FLAGS_WIDTH(4)) bus ();

   alu_result_stage #(.WORD_WIDTH(32), .REG_IDX_WIDTH(4),
                      .FLAGS_WIDTH(4)) dut (
      .clk   (clk),
      .rst   (rst),
      .flush (flush),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Monitor: pop on drain, push on accept, both as seen at the next edge
   always @(negedge clk) begin
      logic [36:0] got;
      logic [36:0] exp;
      if (!rst && !flush && bus.out_valid && bus.out_ready) begin
         got = {bus.out_write_reg, bus.out_dest_reg, bus.out_result};
         tests++;
         delivered++;
         if (sb_q.size() == 0) begin
            fails++;
            $display("FAIL sb_unexpected got=%h required=none", got);
         end else begin
            exp = sb_q.pop_front();
            if (got !== exp) begin
               fails++;
               $display("FAIL sb_order got=%h required=%h", got, exp);
            end
         end
      end
      if (bus.in_valid && bus.in_ready) begin
         sb_q.push_back({bus.in_write_reg, bus.in_dest_reg, bus.in_result});
      end
   end

   task automatic drive(input logic v, input logic [31:0] r,
                        input logic [3:0] d, input logic w,
                        input logic [3:0] f, input logic u);
      bus.in_valid        = v;
      bus.in_result       = r;
      bus.in_dest_reg     = d;
      bus.in_write_reg    = w;
      bus.in_flags        = f;
      bus.in_update_flags = u;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      flush = 1'b0;
      bus.out_ready = 1'b0;
      drive(1'b0, 32'h0, 4'h0, 1'b0, 4'h0, 1'b0);
      repeat (3) step();
      @(negedge clk);
      tests++;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0) begin
         fails++;
         $display("FAIL reset_during valid=%b ready=%b required=0/0",
                  bus.out_valid, bus.in_ready);
      end
      step();
      rst = 1'b0;
      step();
      @(negedge clk);
      tests++;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 ||
          bus.cur_flags !== 4'h0 || bus.out_result !== 32'h0) begin
         fails++;
         $display("FAIL reset_idle v=%b rdy=%b f=%h r=%h required=0/1/0/0",
                  bus.out_valid, bus.in_ready, bus.cur_flags,
                  bus.out_result);
      end
      exp_flags = 4'h0;
   endtask

   task automatic test_latency();
      step();
      bus.out_ready = 1'b1;
      drive(1'b1, 32'h0000_00FF, 4'd3, 1'b1, 4'h0, 1'b0);
      step();
      drive(1'b0, 32'h0, 4'h0, 1'b0, 4'h0, 1'b0);
      @(negedge clk);
      tests++;
      if (bus.out_valid !== 1'b1 || bus.out_result !== 32'h0000_00FF ||
          bus.out_dest_reg !== 4'd3 || bus.out_write_reg !== 1'b1) begin
         fails++;
         $display("FAIL latency v=%b r=%h d=%0d w=%b required=1/ff/3/1",
                  bus.out_valid, bus.out_result, bus.out_dest_reg,
                  bus.out_write_reg);
      end
      step();
   endtask

   task automatic test_back_to_back();
      int start;
      start = delivered;
      bus.out_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         drive(1'b1, 32'h1000 + i, 4'(i), i[0], 4'h0, 1'b0);
         @(negedge clk);
         tests++;
         if (bus.in_ready !== 1'b1) begin
            fails++;
            $display("FAIL b2b_ready beat=%0d got=%b required=1",
                     i, bus.in_ready);
         end
         step();
      end
      drive(1'b0, 32'h0, 4'h0, 1'b0, 4'h0, 1'b0);
      repeat (3) step();
      tests++;
      if (delivered - start !== 8 || sb_q.size() != 0) begin
         fails++;
         $display("FAIL b2b_count got=%0d left=%0d required=8/0",
                  delivered - start, sb_q.size());
      end
   endtask

   task automatic test_backpressure();
      bus.out_ready = 1'b0;
      drive(1'b1, 32'h1, 4'd1, 1'b1, 4'h0, 1'b0);
      step();
      drive(1'b1, 32'h2, 4'd2, 1'b1, 4'h0, 1'b0);
      step();
      drive(1'b1, 32'h3, 4'd4, 1'b0, 4'h0, 1'b0);
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         tests++;
         if (bus.in_ready !== 1'b0 || bus.out_result !== 32'h1) begin
            fails++;
            $display("FAIL bp_stall rdy=%b r=%h required=0/1",
                     bus.in_ready, bus.out_result);
         end
         step();
      end
      bus.out_ready = 1'b1;
      @(negedge clk);
      tests++;
      if (bus.out_result !== 32'h1 || bus.in_ready !== 1'b0) begin
         fails++;
         $display("FAIL bp_a r=%h rdy=%b required=1/0",
                  bus.out_result, bus.in_ready);
      end
      step();
      @(negedge clk);
      tests++;
      if (bus.out_result !== 32'h2 || bus.in_ready !== 1'b1) begin
         fails++;
         $display("FAIL bp_b r=%h rdy=%b required=2/1",
                  bus.out_result, bus.in_ready);
      end
      step();
      drive(1'b0, 32'h0, 4'h0, 1'b0, 4'h0, 1'b0);
      @(negedge clk);
      tests++;
      if (bus.out_valid !== 1'b1 || bus.out_result !== 32'h3) begin
         fails++;
         $display("FAIL bp_c v=%b r=%h required=1/3",
                  bus.out_valid, bus.out_result);
      end
      step();
      step();
   endtask

   task automatic test_flags();
      bus.out_ready = 1'b0;
      exp_flags = 4'h0;
      exp_flags[FLAG_Z] = 1'b1;
      exp_flags[FLAG_C] = 1'b1;
      drive(1'b1, 32'h10, 4'd5, 1'b1, exp_flags, 1'b1);
      step();
      drive(1'b1, 32'h11, 4'd6, 1'b1, 4'hC, 1'b0);
      @(negedge clk);
      tests++;
      if (bus.cur_flags !== exp_flags) begin
         fails++;
         $display("FAIL flags_commit got=%h required=%h",
                  bus.cur_flags, exp_flags);
      end
      step();
      drive(1'b0, 32'h0, 4'h0, 1'b0, 4'h0, 1'b0);
      @(negedge clk);
      tests++;
      if (bus.cur_flags !== exp_flags) begin
         fails++;
         $display("FAIL flags_hold got=%h required=%h",
                  bus.cur_flags, exp_flags);
      end
      step();
      bus.out_ready = 1'b1;
      repeat (3) step();
   endtask

   task automatic test_flush();
      logic [3:0] nf;
      nf = 4'h0;
      nf[FLAG_N] = 1'b1;
      nf[FLAG_V] = 1'b1;
      bus.out_ready = 1'b0;
      drive(1'b1, 32'hA, 4'd7, 1'b1, 4'h0, 1'b0);
      step();
      drive(1'b1, 32'hB, 4'd8, 1'b1, 4'h0, 1'b0);
      step();
      drive(1'b1, 32'hD, 4'd9, 1'b1, nf, 1'b1);
      flush = 1'b1;
      @(negedge clk);
      tests++;
      if (bus.in_ready !== 1'b0) begin
         fails++;
         $display("FAIL flush_ready got=%b required=0", bus.in_ready);
      end
      step();
      flush = 1'b0;
      drive(1'b0, 32'h0, 4'h0, 1'b0, 4'h0, 1'b0);
      sb_q.delete();
      @(negedge clk);
      tests++;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 ||
          bus.cur_flags !== exp_flags) begin
         fails++;
         $display("FAIL flush_state v=%b rdy=%b f=%h required=0/1/%h",
                  bus.out_valid, bus.in_ready, bus.cur_flags, exp_flags);
      end
      step();
      @(negedge clk);
      tests++;
      if (bus.out_valid !== 1'b0) begin
         fails++;
         $display("FAIL flush_noaccept v=%b required=0", bus.out_valid);
      end
      step();
   endtask

   task automatic test_reset_full();
      bus.out_ready = 1'b0;
      drive(1'b1, 32'h55, 4'd10, 1'b1, 4'h6, 1'b1);
      step();
      drive(1'b1, 32'h66, 4'd11, 1'b1, 4'h0, 1'b0);
      step();
      drive(1'b0, 32'h0, 4'h0, 1'b0, 4'h0, 1'b0);
      @(negedge clk);
      tests++;
      if (bus.cur_flags !== 4'h6 || bus.in_ready !== 1'b0) begin
         fails++;
         $display("FAIL rstfull_pre f=%h rdy=%b required=6/0",
                  bus.cur_flags, bus.in_ready);
      end
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      sb_q.delete();
      @(negedge clk);
      tests++;
      if (bus.out_valid !== 1'b0 || bus.out_result !== 32'h0 ||
          bus.out_write_reg !== 1'b0 || bus.out_dest_reg !== 4'h0 ||
          bus.cur_flags !== 4'h0 || bus.in_ready !== 1'b1) begin
         fails++;
         $display("FAIL rstfull v=%b r=%h w=%b d=%h f=%h rdy=%b required=0s,rdy=1",
                  bus.out_valid, bus.out_result, bus.out_write_reg,
                  bus.out_dest_reg, bus.cur_flags, bus.in_ready);
      end
      step();
   endtask

   initial begin
      tests = 0;
      fails = 0;
      delivered = 0;
      exp_flags = 4'h0;
      test_reset();
      test_latency();
      test_back_to_back();
      test_backpressure();
      test_flags();
      test_flush();
      test_reset_full();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
